// File: rtl/tx_unit.sv
// Result-RAM to HPS transmit engine: fetches one word per burst, presents it on PIO_IN,
// and waits for the HPS to consume it. A stall watchdog aborts a session the HPS abandons.
module tx_unit #(
    parameter int unsigned PIO_DATA_WIDTH   = 128,
    parameter int unsigned RESULT_RAM_WIDTH = 8,
    parameter int unsigned BURST_SIZE_WIDTH = 16,
    parameter int unsigned TX_WD_DEPTH      = 16
) (
    input  logic                        clk_in,
    input  logic                        rst_n,
    input  logic                        Clear_buff,
    input  logic                        tx_enable,
    input  logic                        read,
    input  logic [BURST_SIZE_WIDTH-1:0] tx_bursts,
    input  logic [TX_WD_DEPTH-1:0]      watchdog_tx_conf,
    input  logic [PIO_DATA_WIDTH-1:0]   result_rdata,
    output logic [RESULT_RAM_WIDTH-1:0] result_addr,
    output logic                        result_read,
    output logic [PIO_DATA_WIDTH-1:0]   PIO_IN,
    output logic                        tx_valid,
    output logic                        TX_done,
    output logic                        watchdog_tx_trigger,
    output logic [BURST_SIZE_WIDTH-1:0] tx_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PRESENT,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t                      state;
    logic [BURST_SIZE_WIDTH-1:0] bursts_q;
    logic [TX_WD_DEPTH-1:0]      wd_cnt;
    logic                        load_wait;

    logic                        consume_c;
    logic [BURST_SIZE_WIDTH-1:0] count_inc_c;
    logic [TX_WD_DEPTH-1:0]      wd_inc_c;
    logic                        wd_expire_c;

    // Consume/expiry decode; the watchdog increment saturates instead of wrapping.
    always_comb begin
        consume_c   = (state == S_PRESENT) && read && tx_enable;
        count_inc_c = tx_count + BURST_SIZE_WIDTH'(1);
        wd_inc_c    = (&wd_cnt) ? wd_cnt : wd_cnt + TX_WD_DEPTH'(1);
        wd_expire_c = (watchdog_tx_conf != '0) && (wd_inc_c == watchdog_tx_conf);
    end

    // Session FSM. LOAD spends one clock covering the RAM read latency before capturing.
    always_ff @(posedge clk_in) begin
        if (!rst_n || Clear_buff) begin
            state               <= S_IDLE;
            bursts_q            <= '0;
            wd_cnt              <= '0;
            load_wait           <= 1'b0;
            result_addr         <= '0;
            result_read         <= 1'b0;
            PIO_IN              <= '0;
            tx_valid            <= 1'b0;
            TX_done             <= 1'b0;
            watchdog_tx_trigger <= 1'b0;
            tx_count            <= '0;
        end else begin
            result_read <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tx_enable && (tx_bursts != '0)) begin
                        bursts_q    <= tx_bursts;
                        result_addr <= '0;
                        tx_count    <= '0;
                        state       <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    result_read <= 1'b1;
                    load_wait   <= 1'b1;
                    state       <= S_LOAD;
                end
                S_LOAD: begin
                    if (load_wait) begin
                        load_wait <= 1'b0;
                    end else begin
                        PIO_IN   <= result_rdata;
                        tx_valid <= 1'b1;
                        wd_cnt   <= '0;
                        state    <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    // A consume on the expiry clock takes precedence over the timeout.
                    if (consume_c) begin
                        tx_count    <= count_inc_c;
                        result_addr <= result_addr + RESULT_RAM_WIDTH'(1);
                        tx_valid    <= 1'b0;
                        wd_cnt      <= '0;
                        if (count_inc_c == bursts_q) begin
                            TX_done <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            state   <= S_FETCH;
                        end
                    end else if (wd_expire_c) begin
                        wd_cnt              <= wd_inc_c;
                        tx_valid            <= 1'b0;
                        watchdog_tx_trigger <= 1'b1;
                        state               <= S_TIMEOUT;
                    end else begin
                        wd_cnt <= wd_inc_c;
                    end
                end
                S_DONE, S_TIMEOUT: begin
                    state <= state;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/tx_unit.md
TX_UNIT -- requirements
Module: TX_UNIT

Interface
REQ-001 Parameter PIO_DATA_WIDTH, default 128, width of one burst word returned to the HPS.
REQ-002 Parameter RESULT_RAM_WIDTH, default 8, result-RAM address width.
REQ-003 Parameter BURST_SIZE_WIDTH, default 16, burst-count width.
REQ-004 Parameter TX_WD_DEPTH, default 16, watchdog threshold width.
REQ-005 clk_in  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 Clear_buff  in  1  synchronous session abort/clear.
REQ-008 tx_enable  in  1  HPS ready to read; start qualifier and read qualifier.
REQ-009 read  in  1  HPS read strobe; consumes the word on PIO_IN.
REQ-010 tx_bursts  in  BURST_SIZE_WIDTH  words to send; latched at session start.
REQ-011 watchdog_tx_conf  in  TX_WD_DEPTH  stall limit in clocks; 0 disables the watchdog.
REQ-012 result_rdata  in  PIO_DATA_WIDTH  result-RAM read data; 1-clock latency after result_read.
REQ-013 result_addr  out  RESULT_RAM_WIDTH  result-RAM read address.
REQ-014 result_read  out  1  result-RAM read enable.
REQ-015 PIO_IN  out  PIO_DATA_WIDTH  registered word presented to the HPS.
REQ-016 tx_valid  out  1  PIO_IN holds an unconsumed word.
REQ-017 TX_done  out  1  all words consumed; level until cleared.
REQ-018 watchdog_tx_trigger  out  1  sticky stall flag.
REQ-019 tx_count  out  BURST_SIZE_WIDTH  words consumed this session.

Function
REQ-020 FSM states: IDLE, FETCH, LOAD, PRESENT, DONE, TIMEOUT.
REQ-021 IDLE: when tx_enable=1 and tx_bursts!=0, latch tx_bursts, set result_addr=0 and tx_count=0, then go to FETCH; when tx_bursts==0, stay in IDLE.
REQ-022 FETCH: result_read=1 for exactly one clock at result_addr, then go to LOAD.
REQ-023 LOAD: register result_rdata into PIO_IN, then go to PRESENT.
REQ-024 PRESENT: tx_valid=1; PIO_IN is stable until consumed.
REQ-025 Word consumed when read=1 and tx_enable=1 in PRESENT; read while tx_enable=0 is ignored.
REQ-026 On consume: tx_count+1, result_addr+1 (wrap modulo 2^RESULT_RAM_WIDTH), tx_valid=0 at the next edge; go to DONE if the new tx_count equals the latched bursts, else go to FETCH.
REQ-027 read outside PRESENT is ignored; it has no effect on count or address.
REQ-028 Latency: tx_valid rises 3 clocks after the start edge and 3 clocks after each consume edge.
REQ-029 Watchdog counter clears on entry to PRESENT and on each consume.
REQ-030 Watchdog counter increments each PRESENT clock with no consume; it saturates and does not wrap.
REQ-031 When the watchdog counter equals watchdog_tx_conf (nonzero), go to TIMEOUT: tx_valid=0, watchdog_tx_trigger=1.
REQ-032 TIMEOUT is held until Clear_buff or reset.
REQ-033 DONE: TX_done=1, tx_valid=0, tx_count held; DONE is held until Clear_buff or reset; tx_enable is ignored in DONE.
REQ-034 Clear_buff=1 has priority over all events: next state IDLE, all outputs at reset values.
REQ-035 Consume coincident with watchdog expiry: the consume wins.
REQ-036 Changes to tx_bursts mid-session are ignored.

Reset
REQ-037 rst_n=0 at a rising edge: state IDLE.
REQ-038 Under reset all outputs are 0: PIO_IN, result_addr, tx_count, result_read, tx_valid, TX_done, watchdog_tx_trigger.
REQ-039 Under reset the internal counters are 0.
REQ-040 Reset mid-session aborts the session with no further RAM reads.

Verification
REQ-041 Basic session: tx_bursts=3, RAM[i]=i+1, tx_enable=1, read pulsed on each tx_valid -> PIO_IN sequence 1,2,3; result_addr 0,1,2; TX_done=1; tx_count=3.
REQ-042 Latency check: start edge -> tx_valid high exactly 3 clocks later; result_read high 1 clock per word.
REQ-043 Stall: tx_bursts=2, watchdog_tx_conf=10, no read -> watchdog_tx_trigger=1 after 10 PRESENT clocks, tx_valid=0; trigger is held; Clear_buff returns the block to IDLE with all outputs 0.
REQ-044 Qualifier: read=1 with tx_enable=0 in PRESENT -> tx_count unchanged, PIO_IN unchanged; watchdog_tx_conf=0 with no read for 100 clocks -> no trigger.
REQ-045 Wrap: RESULT_RAM_WIDTH=2, tx_bursts=6 -> result_addr 0,1,2,3,0,1; TX_done after the 6th consume.
REQ-046 Abort: Clear_buff or rst_n=0 asserted in LOAD after 1 consume -> next clock IDLE, tx_count=0, tx_valid=0; a new session with tx_bursts=0 stays in IDLE.
